// File: rtl/sdsu_bus_pkg.sv
// Shared types and constants for the SDSU bus master: FSM state encoding,
// bus constants and the Galois LFSR step used for operand generation.
package sdsu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    GAP,
    ST,
    WAIT_RDY,
    RD,
    CAP,
    DONE
  } state_t;

  localparam logic [31:0] START_ADDR = 32'h0000_0000;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] DATA_START = 32'h0000_0001;

  // Right-shifting Galois form: the bit shifted out folds the tap mask back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/bus_master_seq_if.sv
// SDSU register-file bus: master drives the beat, slave returns ready and read data.
interface bus_master_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              exec;
  logic              write;
  logic              start;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic [DATA_W-1:0] result_data;

  modport master (
    output valid, exec, write, start, address, data,
    input  ready, result_data
  );

  modport slave (
    input  valid, exec, write, start, address, data,
    output ready, result_data
  );
endinterface

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR; q is the value the register steps to on this load/en,
// so the caller can register it as an operand in the same cycle.
module lfsr32
  import sdsu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] state_q;
  logic [31:0] base;

  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    base = load ? ((seed == 32'd0) ? 32'd1 : seed) : state_q;
    q    = lfsr_step(base);
  end

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= 32'd1;
    end else if (load || en) begin
      state_q <= q;
    end
  end

endmodule

// File: rtl/bus_master_seq.sv
// SDSU bus master: per transaction writes NUM_OPS operands, issues a start beat,
// waits for ready (with watchdog), reads the result; repeats num_txn times per go.
module bus_master_seq
  import sdsu_bus_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          NUM_OPS     = 2,
  parameter int unsigned RESULT_ADDR = 'hF,
  parameter int          TIMEOUT     = 1024,
  parameter int          CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_txn,
  bus_master_seq_if.master  bus,
  output logic [DATA_W-1:0] result_q,
  output logic              result_vld,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  txn_count
);

  localparam int OP_W   = 4;
  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t              state;
  logic [OP_W-1:0]     op;
  logic [WCNT_W-1:0]   wcnt;
  logic [DATA_W-1:0]   inc_val;
  logic [DATA_W-1:0]   inc_cur;
  logic [DATA_W-1:0]   operand;
  logic                mode_q;
  logic [CNT_W-1:0]    num_q;
  logic                wr_issue;
  logic                lfsr_load;
  logic [31:0]         lfsr_next;

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_issue),
    .load  (lfsr_load),
    .seed  (32'(seed)),
    .q     (lfsr_next)
  );

  // Operand for a write beat issued this edge; on go, mode and counter start fresh.
  always_comb begin
    lfsr_load = (state == IDLE) && go;
    wr_issue  = lfsr_load
             || ((state == GAP) && (op < OP_W'(NUM_OPS)))
             || ((state == CAP) && (txn_count < num_q));
    inc_cur   = (state == IDLE) ? DATA_W'(1) : inc_val;
    operand   = (((state == IDLE) ? mode : mode_q) != 1'b0) ? inc_cur : DATA_W'(lfsr_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= '0;
      wcnt        <= '0;
      inc_val     <= '0;
      mode_q      <= 1'b0;
      num_q       <= '0;
      bus.valid   <= 1'b0;
      bus.exec    <= 1'b0;
      bus.write   <= 1'b1;
      bus.start   <= 1'b0;
      bus.address <= '0;
      bus.data    <= '0;
      result_q    <= '0;
      result_vld  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      txn_count   <= '0;
    end else begin
      bus.valid  <= 1'b0;
      bus.exec   <= 1'b0;
      bus.write  <= 1'b1;
      result_vld <= 1'b0;
      done       <= 1'b0;

      case (state)
        IDLE: begin
          if (go) begin
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            txn_count   <= '0;
            mode_q      <= mode;
            num_q       <= (num_txn == '0) ? CNT_W'(1) : num_txn;
          end
        end
        WR: begin
          state <= GAP;
          op    <= op + OP_W'(1);
        end
        GAP: begin
          if (!wr_issue) begin
            state       <= ST;
            bus.valid   <= 1'b1;
            bus.exec    <= 1'b1;
            bus.start   <= 1'b1;
            bus.address <= ADDR_W'(START_ADDR);
            bus.data    <= DATA_W'(DATA_START);
            op          <= '0;
          end
        end
        ST: begin
          state <= WAIT_RDY;
          wcnt  <= '0;
        end
        WAIT_RDY: begin
          if (bus.ready) begin
            state       <= RD;
            bus.start   <= 1'b0;
            bus.valid   <= 1'b1;
            bus.exec    <= 1'b1;
            bus.write   <= 1'b0;
            bus.address <= ADDR_W'(RESULT_ADDR);
          end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
            state       <= DONE;
            bus.start   <= 1'b0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        RD: begin
          state      <= CAP;
          result_q   <= bus.result_data;
          result_vld <= 1'b1;
          txn_count  <= txn_count + CNT_W'(1);
        end
        CAP: begin
          if (!wr_issue) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // All write beats share one issue path; it overrides the case defaults above.
      if (wr_issue) begin
        state       <= WR;
        bus.valid   <= 1'b1;
        bus.exec    <= 1'b1;
        bus.address <= ADDR_W'(op) + ADDR_W'(1);
        bus.data    <= operand;
        inc_val     <= inc_cur + DATA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_master_seq.sv
// Self-checking bench for bus_master_seq: a slave responder drives ready/result_data
// and a queue-based model of the beat sequence supplies every expected value.
module tb_bus_master_seq;
  localparam int          NUM_OPS  = 2;
  localparam int          TIMEOUT  = 16;
  localparam int          CNT_W    = 8;
  localparam logic [31:0] RES_ADDR = 32'hF;
  localparam logic [31:0] TAPS     = 32'h8020_0003;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic        st;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             go = 1'b0;
  logic             mode = 1'b0;
  logic [31:0]      seed = '0;
  logic [CNT_W-1:0] num_txn = '0;
  logic [31:0]      result_q;
  logic             result_vld, busy, done, timeout_err;
  logic [CNT_W-1:0] txn_count;

  bus_master_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bus_master_seq #(
    .ADDR_W(32), .DATA_W(32), .NUM_OPS(NUM_OPS), .RESULT_ADDR('hF),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .seed(seed), .num_txn(num_txn),
    .bus(bus), .result_q(result_q), .result_vld(result_vld), .busy(busy),
    .done(done), .timeout_err(timeout_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  beat_t       obs_beats[$];
  beat_t       exp_beats[$];
  logic [31:0] obs_res[$];
  logic [31:0] res_tab[16];
  int          done_cnt, start_cyc, st_cyc, first_te, busy_bad, exec_bad;
  logic        te_at_done, te_after_go, post_busy, post_done;
  logic [CNT_W-1:0] tc_at_done;
  bit          hung;

  function automatic logic [31:0] model_lfsr(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? TAPS : 32'h0);
  endfunction

  // Expected beat list: NUM_OPS operand writes, start beat, read beat per transaction.
  task automatic build_expect(input bit md, input logic [31:0] sd, input int n, input bit to);
    logic [31:0] x = (sd == 32'd0) ? 32'd1 : sd;
    logic [31:0] v = 32'd1;
    logic [31:0] val;
    exp_beats.delete();
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        if (md) begin val = v; v = v + 1; end
        else begin x = model_lfsr(x); val = x; end
        exp_beats.push_back('{32'(k + 1), val, 1'b1, 1'b0});
      end
      exp_beats.push_back('{32'h0, 32'h1, 1'b1, 1'b1});
      if (to) break;
      exp_beats.push_back('{RES_ADDR, 32'h0, 1'b0, 1'b0});
    end
  endtask

  function automatic int beat_mismatch();
    int lim = (obs_beats.size() > exp_beats.size()) ? obs_beats.size() : exp_beats.size();
    for (int i = 0; i < lim; i++) begin
      if (i >= obs_beats.size() || i >= exp_beats.size()) return i;
      if (obs_beats[i].addr !== exp_beats[i].addr || obs_beats[i].wr !== exp_beats[i].wr ||
          obs_beats[i].st !== exp_beats[i].st ||
          (exp_beats[i].wr && obs_beats[i].data !== exp_beats[i].data)) return i;
    end
    return -1;
  endfunction

  // Pulses go, then acts as the slave and records everything the master does until done.
  task automatic run_seq(input bit md, input logic [31:0] sd, input int n, input int d,
                         input bit pre_rdy, input bit go_mid);
    int ridx = 0;
    bit waiting = 0;
    obs_beats.delete(); obs_res.delete();
    done_cnt = 0; start_cyc = 0; st_cyc = -1; first_te = -1; busy_bad = 0; exec_bad = 0;
    hung = 1; te_at_done = 1'b0; tc_at_done = '0; te_after_go = 1'bx;
    @(negedge clk);
    go = 1'b1; mode = md; seed = sd; num_txn = CNT_W'(n); bus.ready = pre_rdy;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin go = 1'b0; te_after_go = timeout_err; end
      if (go_mid && cyc == 2) begin go = 1'b1; mode = ~md; seed = ~sd; num_txn = CNT_W'(n + 3); end
      if (go_mid && cyc == 3) begin go = 1'b0; mode = md; seed = sd; num_txn = CNT_W'(n); end
      if (busy !== 1'b1) busy_bad++;
      if (bus.exec !== bus.valid) exec_bad++;
      if (bus.start === 1'b1) start_cyc++;
      if (timeout_err === 1'b1 && first_te < 0) first_te = cyc;
      if (result_vld === 1'b1) obs_res.push_back(result_q);
      if (bus.valid === 1'b1) begin
        obs_beats.push_back('{bus.address, bus.data, bus.write, bus.start});
        if (bus.start) begin st_cyc = cyc; waiting = 1; bus.result_data = res_tab[ridx % 16]; end
        if (!bus.write) begin waiting = 0; ridx++; if (!pre_rdy) bus.ready = 1'b0; end
      end
      if (waiting && d >= 0 && cyc >= st_cyc + d) bus.ready = 1'b1;
      if (done === 1'b1) begin
        done_cnt++; te_at_done = timeout_err; tc_at_done = txn_count; hung = 0;
        break;
      end
    end
    @(negedge clk);
    post_busy = busy; post_done = done;
    bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_chk++; if (bus.exec !== 1'b0) begin n_err++; $display("FAIL reset_exec: got %b want 0", bus.exec); end
    n_chk++; if (bus.write !== 1'b1) begin n_err++; $display("FAIL reset_write: got %b want 1", bus.write); end
    n_chk++; if (bus.start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", bus.start); end
    n_chk++; if (bus.address !== 32'h0) begin n_err++; $display("FAIL reset_address: got %h want 0", bus.address); end
    n_chk++; if (bus.data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.data); end
    n_chk++; if (result_q !== 32'h0) begin n_err++; $display("FAIL reset_result_q: got %h want 0", result_q); end
    n_chk++; if (result_vld !== 1'b0) begin n_err++; $display("FAIL reset_result_vld: got %b want 0", result_vld); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_chk++; if (txn_count !== '0) begin n_err++; $display("FAIL reset_txn_count: got %0d want 0", txn_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int bad;
    res_tab[0] = 32'd42;
    run_seq(1'b1, 32'h0, 1, 3, 1'b0, 1'b0);
    build_expect(1'b1, 32'h0, 1, 1'b0);
    bad = beat_mismatch();
    n_chk++; if (hung !== 1'b0) begin n_err++; $display("FAIL single_hang: no done within budget"); end
    n_chk++; if (bad !== -1) begin n_err++; $display("FAIL single_beats: idx %0d got %h want %h", bad, obs_beats[bad], exp_beats[bad]); end
    n_chk++; if (obs_res.size() !== 1) begin n_err++; $display("FAIL single_vld_count: got %0d want 1", obs_res.size()); end
    n_chk++; if (obs_res[0] !== 32'd42) begin n_err++; $display("FAIL single_result: got %0d want 42", obs_res[0]); end
    n_chk++; if (tc_at_done !== CNT_W'(1)) begin n_err++; $display("FAIL single_txn_count: got %0d want 1", tc_at_done); end
    n_chk++; if (done_cnt !== 1) begin n_err++; $display("FAIL single_done: got %0d want 1", done_cnt); end
    n_chk++; if (start_cyc !== 4) begin n_err++; $display("FAIL single_start_len: got %0d want 4", start_cyc); end
    n_chk++; if (busy_bad !== 0 || exec_bad !== 0) begin n_err++; $display("FAIL single_busy_exec: busy_bad %0d exec_bad %0d want 0", busy_bad, exec_bad); end
    n_chk++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin n_err++; $display("FAIL single_post: busy %b done %b want 0 0", post_busy, post_done); end
    n_chk++; if (te_at_done !== 1'b0) begin n_err++; $display("FAIL single_timeout_err: got %b want 0", te_at_done); end
  endtask

  task automatic test_multi();
    int bad;
    int d = $urandom_range(1, 10);
    for (int i = 0; i < 16; i++) res_tab[i] = $urandom;
    run_seq(1'b1, 32'h0, 3, d, 1'b0, 1'b0);
    build_expect(1'b1, 32'h0, 3, 1'b0);
    bad = beat_mismatch();
    n_chk++; if (bad !== -1) begin n_err++; $display("FAIL multi_beats: idx %0d got %h want %h", bad, obs_beats[bad], exp_beats[bad]); end
    n_chk++; if (obs_res.size() !== 3) begin n_err++; $display("FAIL multi_vld_count: got %0d want 3", obs_res.size()); end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (obs_res[i] !== res_tab[i]) begin n_err++; $display("FAIL multi_result%0d: got %h want %h", i, obs_res[i], res_tab[i]); end
    end
    n_chk++; if (tc_at_done !== CNT_W'(3)) begin n_err++; $display("FAIL multi_txn_count: got %0d want 3", tc_at_done); end
    n_chk++; if (start_cyc !== 3 * (d + 1)) begin n_err++; $display("FAIL multi_start_len: got %0d want %0d", start_cyc, 3 * (d + 1)); end
    n_chk++; if (result_q !== res_tab[2]) begin n_err++; $display("FAIL multi_result_q: got %h want %h", result_q, res_tab[2]); end
  endtask

  task automatic test_lfsr();
    int bad;
    int n = $urandom_range(1, 3);
    logic [31:0] first_seq[$];
    logic [31:0] sd;
    run_seq(1'b0, 32'h0, n, $urandom_range(1, 6), 1'b0, 1'b0);
    build_expect(1'b0, 32'h0, n, 1'b0);
    bad = beat_mismatch();
    n_chk++; if (bad !== -1) begin n_err++; $display("FAIL lfsr_beats: idx %0d got %h want %h", bad, obs_beats[bad], exp_beats[bad]); end
    n_chk++; if (obs_beats[0].data !== TAPS) begin n_err++; $display("FAIL lfsr_first: got %h want %h", obs_beats[0].data, TAPS); end
    foreach (obs_beats[i]) if (obs_beats[i].wr) first_seq.push_back(obs_beats[i].data);
    run_seq(1'b0, 32'h0, n, $urandom_range(1, 6), 1'b0, 1'b0);
    for (int i = 0, j = 0; i < obs_beats.size(); i++) begin
      if (obs_beats[i].wr) begin
        n_chk++; if (obs_beats[i].data !== first_seq[j]) begin n_err++; $display("FAIL lfsr_rerun%0d: got %h want %h", j, obs_beats[i].data, first_seq[j]); end
        j++;
      end
    end
    sd = $urandom | 32'h1;
    run_seq(1'b0, sd, 2, $urandom_range(1, 6), 1'b0, 1'b0);
    build_expect(1'b0, sd, 2, 1'b0);
    bad = beat_mismatch();
    n_chk++; if (bad !== -1) begin n_err++; $display("FAIL lfsr_seed_beats: seed %h idx %0d got %h want %h", sd, bad, obs_beats[bad], exp_beats[bad]); end
  endtask

  task automatic test_timeout();
    int bad;
    logic [31:0] sd;
    run_seq(1'b1, 32'h0, 2, -1, 1'b0, 1'b0);
    build_expect(1'b1, 32'h0, 2, 1'b1);
    bad = beat_mismatch();
    n_chk++; if (hung !== 1'b0) begin n_err++; $display("FAIL timeout_hang: no done within budget"); end
    n_chk++; if (bad !== -1) begin n_err++; $display("FAIL timeout_beats: idx %0d got %h want %h", bad, obs_beats[bad], exp_beats[bad]); end
    n_chk++; if (te_at_done !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", te_at_done); end
    n_chk++; if (first_te !== st_cyc + 1 + TIMEOUT) begin n_err++; $display("FAIL timeout_cycle: got %0d want %0d", first_te, st_cyc + 1 + TIMEOUT); end
    n_chk++; if (start_cyc !== TIMEOUT + 1) begin n_err++; $display("FAIL timeout_start_len: got %0d want %0d", start_cyc, TIMEOUT + 1); end
    n_chk++; if (tc_at_done !== '0) begin n_err++; $display("FAIL timeout_txn_count: got %0d want 0", tc_at_done); end
    n_chk++; if (obs_res.size() !== 0) begin n_err++; $display("FAIL timeout_vld: got %0d pulses want 0", obs_res.size()); end
    n_chk++; if (timeout_err !== 1'b1 || post_busy !== 1'b0) begin n_err++; $display("FAIL timeout_sticky: err %b busy %b want 1 0", timeout_err, post_busy); end
    sd = $urandom;
    run_seq(1'b0, sd, 1, 2, 1'b0, 1'b0);
    build_expect(1'b0, sd, 1, 1'b0);
    bad = beat_mismatch();
    n_chk++; if (te_after_go !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b want 0", te_after_go); end
    n_chk++; if (bad !== -1) begin n_err++; $display("FAIL timeout_next_beats: idx %0d got %h want %h", bad, obs_beats[bad], exp_beats[bad]); end
  endtask

  task automatic test_zero_txn();
    int bad;
    logic [31:0] sd = $urandom;
    run_seq(1'b0, sd, 0, $urandom_range(1, 6), 1'b0, 1'b0);
    build_expect(1'b0, sd, 1, 1'b0);
    bad = beat_mismatch();
    n_chk++; if (bad !== -1) begin n_err++; $display("FAIL zero_txn_beats: idx %0d got %h want %h", bad, obs_beats[bad], exp_beats[bad]); end
    n_chk++; if (tc_at_done !== CNT_W'(1)) begin n_err++; $display("FAIL zero_txn_count: got %0d want 1", tc_at_done); end
  endtask

  task automatic test_abort_and_busy_go();
    int bad;
    int seen = 0;
    int stray = 0;
    @(negedge clk);
    go = 1'b1; mode = 1'b1; num_txn = CNT_W'(2);
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.start === 1'b1) seen = 1;
    end
    n_chk++; if (seen !== 1) begin n_err++; $display("FAIL abort_no_start: start never seen"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || bus.start !== 1'b0 || bus.valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_ctrl: busy %b start %b valid %b done %b want 0 0 0 0", busy, bus.start, bus.valid, done); end
    n_chk++; if (bus.write !== 1'b1 || txn_count !== '0 || result_q !== 32'h0) begin
      n_err++; $display("FAIL abort_vals: write %b txn_count %0d result_q %h want 1 0 0", bus.write, txn_count, result_q); end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || bus.valid !== 1'b0) stray++;
    end
    n_chk++; if (stray !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles want 0", stray); end
    run_seq(1'b1, 32'h0, 2, 0, 1'b1, 1'b1);
    build_expect(1'b1, 32'h0, 2, 1'b0);
    bad = beat_mismatch();
    n_chk++; if (bad !== -1) begin n_err++; $display("FAIL busy_go_beats: idx %0d got %h want %h", bad, obs_beats[bad], exp_beats[bad]); end
    n_chk++; if (start_cyc !== 4) begin n_err++; $display("FAIL early_ready_start_len: got %0d want 4", start_cyc); end
    n_chk++; if (tc_at_done !== CNT_W'(2)) begin n_err++; $display("FAIL busy_go_txn_count: got %0d want 2", tc_at_done); end
  endtask

  initial begin
    bus.ready = 1'b0;
    bus.result_data = '0;
    for (int i = 0; i < 16; i++) res_tab[i] = '0;
    test_reset();
    test_single();
    test_multi();
    test_lfsr();
    test_timeout();
    test_zero_txn();
    test_abort_and_busy_go();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
